// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and defaults for the FIFO read-side stream block
package fifo_rd_pkg;

    // Read-side controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam int DEF_DW        = 16;
    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_CW        = 16;

    localparam int SKID_DEPTH = 2;

    // Index of the final word in a burst, sized to the burst counter
    function automatic logic [DEF_CW-1:0] last_index(input int burst_len);
        return DEF_CW'(burst_len - 1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - valid/ready output stream carrying data and a burst-last flag
interface fifo_rd_stream_if
    import fifo_rd_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry skid buffer absorbing the FIFO read latency
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk_b,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [1:0]    occ_o,
    output logic [DW-1:0] head_o
);

    logic [DW-1:0] mem_q [SKID_DEPTH];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;

    // Occupancy moves by one on push-only or pop-only; simultaneous push/pop leaves it unchanged
    always_comb begin
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage, pointers and occupancy; reset empties the buffer and zeroes the head word
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    // Overflow/underflow guard: the issue logic upstream must never push into a full buffer
    always @(posedge clk_b) begin
        if (rst_n) begin
            assert (!(push_i && occ_q == 2'd2));
            assert (!(pop_i && occ_q == 2'd0));
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the clk_b side of the dual-clock FIFO into a framed valid/ready stream
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CW        = DEF_CW
) (
    input  logic                clk_b,
    input  logic                rst_n,
    input  logic                en,
    input  logic                empty,
    input  logic [DW-1:0]       dout_b,
    output logic                ren_b,
    fifo_rd_stream_if.master    m,
    output logic                busy,
    output logic [CW-1:0]       burst_cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    state_e        state_q;
    state_e        state_d;
    logic          inflight_q;
    logic          inflight_d;
    logic [CW-1:0] burst_cnt_q;
    logic [CW-1:0] burst_cnt_d;

    logic [1:0]    occ;
    logic [DW-1:0] head;
    logic          valid_w;
    logic          pop;
    logic [1:0]    occ_after_pop;
    logic [2:0]    slots_used;

    fifo_rd_skid #(
        .DW (DW)
    ) u_skid (
        .clk_b  (clk_b),
        .rst_n  (rst_n),
        .push_i (inflight_q),
        .pop_i  (pop),
        .din_i  (dout_b),
        .occ_o  (occ),
        .head_o (head)
    );

    assign valid_w   = (occ != 2'd0);
    assign pop       = valid_w && m.m_ready;
    assign m.m_valid = valid_w;
    assign m.m_data  = head;
    assign m.m_last  = valid_w && (burst_cnt_q == LAST_IDX);
    assign busy      = (state_q != ST_IDLE);
    assign burst_cnt = burst_cnt_q;

    // Read issue: a slot freed by this cycle's pop can be reused by a read issued in the same cycle,
    // and the word already in flight reserves one slot because it lands next cycle.
    always_comb begin
        occ_after_pop = occ - {1'b0, pop};
        slots_used    = {1'b0, occ_after_pop} + {2'b00, inflight_q};
        ren_b         = (state_q == ST_RUN) && !empty && (slots_used < 3'd2);
        inflight_d    = ren_b;
    end

    // Controller next state: STOP keeps presenting buffered words until nothing is left or en returns
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (occ == 2'd0 && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst framing: count accepted words, wrap after the last one; survives IDLE so pauses keep framing
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (pop) begin
            if (burst_cnt_q == LAST_IDX) begin
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end
    end

    // State, in-flight flag and burst counter registers
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inflight_q  <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule
